// File: rtl/regr_lane_bank.sv
// regr_lane_bank: LANES independent WIDTH-bit lane registers with per-lane
// load/inc/dec/add/clear, zero and sticky overflow flags, plus a one-entry
// store staging register handshaked with data memory via valid/ack.
module regr_lane_bank #(
  parameter int               WIDTH     = 16,
  parameter int               LANES     = 4,
  parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
  input  logic                   clock,
  input  logic                   rst,
  input  logic [LANES-1:0]       lane_en,
  input  logic [2:0]             op,
  input  logic [LANES*WIDTH-1:0] datain,
  output logic [LANES*WIDTH-1:0] dataout,
  output logic [LANES-1:0]       zero,
  output logic [LANES-1:0]       ovf,
  input  logic                   dm_mem_wr_en,
  output logic [LANES*WIDTH-1:0] dm_mem_out,
  output logic                   dm_valid,
  input  logic                   dm_ack,
  output logic                   dm_drop
);

  localparam logic [2:0] OP_NOP  = 3'b000;
  localparam logic [2:0] OP_LOAD = 3'b001;
  localparam logic [2:0] OP_INC  = 3'b010;
  localparam logic [2:0] OP_DEC  = 3'b011;
  localparam logic [2:0] OP_ADD  = 3'b100;
  localparam logic [2:0] OP_CLR  = 3'b101;

  localparam logic ST_EMPTY = 1'b0;
  localparam logic ST_FULL  = 1'b1;

  logic [LANES*WIDTH-1:0] lane_q, lane_d;
  logic [LANES-1:0]       ovf_q, ovf_d;
  logic [LANES*WIDTH-1:0] dm_out_q, dm_out_d;
  logic                   dm_state_q, dm_state_d;
  logic                   dm_drop_q, dm_drop_d;

  logic [WIDTH-1:0] cur;
  logic [WIDTH-1:0] opnd;
  logic [WIDTH:0]   ext;

  // Lane datapath: apply op to each enabled lane; carry/borrow sets sticky ovf.
  always_comb begin
    // NOTE: every variable gets a default before any branch so no path leaves
    // it unassigned; otherwise synthesis infers a latch.
    lane_d = lane_q;
    ovf_d  = ovf_q;
    cur    = '0;
    opnd   = '0;
    ext    = '0;
    for (int i = 0; i < LANES; i++) begin
      if (lane_en[i]) begin
        cur  = lane_q[i*WIDTH +: WIDTH];
        opnd = datain[i*WIDTH +: WIDTH];
        case (op)
          OP_LOAD: begin
            lane_d[i*WIDTH +: WIDTH] = opnd;
            ovf_d[i]                 = 1'b0;
          end
          OP_INC: begin
            ext                      = {1'b0, cur} + (WIDTH+1)'(1);
            lane_d[i*WIDTH +: WIDTH] = ext[WIDTH-1:0];
            if (ext[WIDTH]) ovf_d[i] = 1'b1;
          end
          OP_DEC: begin
            // Borrow out of the extended subtraction lands in the top bit.
            ext                      = {1'b0, cur} - (WIDTH+1)'(1);
            lane_d[i*WIDTH +: WIDTH] = ext[WIDTH-1:0];
            if (ext[WIDTH]) ovf_d[i] = 1'b1;
          end
          OP_ADD: begin
            ext                      = {1'b0, cur} + {1'b0, opnd};
            lane_d[i*WIDTH +: WIDTH] = ext[WIDTH-1:0];
            if (ext[WIDTH]) ovf_d[i] = 1'b1;
          end
          OP_CLR: begin
            lane_d[i*WIDTH +: WIDTH] = RESET_VAL;
            ovf_d[i]                 = 1'b0;
          end
          default: ; // NOP and reserved encodings hold
        endcase
      end
    end
  end

  // Staging register: capture when empty or when the old entry is acked in
  // the same cycle; a capture against an unacked full entry is dropped.
  always_comb begin
    dm_state_d = dm_state_q;
    dm_out_d   = dm_out_q;
    dm_drop_d  = 1'b0;
    case (dm_state_q)
      ST_EMPTY: begin
        if (dm_mem_wr_en) begin
          dm_out_d   = datain;
          dm_state_d = ST_FULL;
        end
      end
      default: begin
        if (dm_ack) begin
          if (dm_mem_wr_en) dm_out_d = datain;
          else              dm_state_d = ST_EMPTY;
        end else if (dm_mem_wr_en) begin
          dm_drop_d = 1'b1;
        end
      end
    endcase
  end

  // State registers; synchronous reset wins over every other input.
  always_ff @(posedge clock) begin
    // NOTE: sequential state uses non-blocking assignments so all flops
    // update together from pre-edge values, independent of statement order.
    if (rst) begin
      lane_q     <= {LANES{RESET_VAL}};
      ovf_q      <= '0;
      dm_out_q   <= '0;
      dm_state_q <= ST_EMPTY;
      dm_drop_q  <= 1'b0;
    end else begin
      lane_q     <= lane_d;
      ovf_q      <= ovf_d;
      dm_out_q   <= dm_out_d;
      dm_state_q <= dm_state_d;
      dm_drop_q  <= dm_drop_d;
    end
  end

  // Zero flags follow the registers directly.
  always_comb begin
    zero = '0;
    for (int i = 0; i < LANES; i++) begin
      zero[i] = (lane_q[i*WIDTH +: WIDTH] == '0);
    end
  end

  assign dataout    = lane_q;
  assign ovf        = ovf_q;
  assign dm_mem_out = dm_out_q;
  assign dm_valid   = (dm_state_q == ST_FULL);
  assign dm_drop    = dm_drop_q;

endmodule

// File: doc/regr_lane_bank.md
Name: regr_lane_bank

Overview:
Parametrised successor to the single 16-bit core register. Holds LANES independent WIDTH-bit registers, one per processing lane of the matrix-multiply array. Each lane supports load, increment, decrement, accumulate and clear, with per-lane enables, zero and sticky overflow flags. Includes a data-memory staging register with a valid/ack handshake so stores are not lost when memory is busy.

Parameters:
WIDTH, 16, bit width of each lane register
LANES, 4, number of independent lane registers (≥1)
RESET_VAL, 0, value loaded into every lane register on reset and CLR

Ports:
clock  input  1  system clock; all state updates on rising edge
rst  input  1  synchronous, active-high reset
lane_en  input  LANES  per-lane enable for op; bit i selects lane i
op  input  3  operation applied to all enabled lanes (encoding below)
datain  input  LANES*WIDTH  lane i operand at bits [i*WIDTH +: WIDTH]
dataout  output  LANES*WIDTH  current lane register values, same packing
zero  output  LANES  zero[i]=1 when lane i register == 0 (combinational from register)
ovf  output  LANES  sticky overflow/underflow flag per lane
dm_mem_wr_en  input  1  capture datain into memory staging register
dm_mem_out  output  LANES*WIDTH  staged store data
dm_valid  output  1  dm_mem_out holds unconsumed data
dm_ack  input  1  memory consumed dm_mem_out this cycle
dm_drop  output  1  one-cycle pulse: capture request rejected

Behaviour:
- Reset (rst=1 at edge): every lane = RESET_VAL; ovf=0; dm_mem_out=0; dm_valid=0; dm_drop=0. rst overrides every other input that cycle. Reset mid-operation discards any pending staged data.
- op encoding, applied at edge to lanes with lane_en[i]=1; lanes with lane_en[i]=0 hold:
  000 NOP: hold.
  001 LOAD: reg <= datain lane; ovf[i] <= 0.
  010 INC: reg <= reg+1 mod 2^WIDTH; ovf[i] set if reg was all-ones.
  011 DEC: reg <= reg-1 mod 2^WIDTH; ovf[i] set if reg was 0.
  100 ADD: reg <= reg+datain lane, unsigned, mod 2^WIDTH; ovf[i] set on carry out.
  101 CLR: reg <= RESET_VAL; ovf[i] <= 0.
  110, 111: reserved, behave as NOP.
- ovf is sticky: once set, it is cleared only by LOAD, CLR or rst on that lane.
- Latency: result visible on dataout one cycle after the edge; zero tracks dataout with no extra delay.
- Staging register (two states, EMPTY/FULL, mirrored by dm_valid):
  EMPTY + dm_mem_wr_en: capture all lanes of datain; go FULL.
  FULL + dm_ack, no wr_en: go EMPTY; dm_mem_out holds its last value.
  FULL + dm_ack + wr_en in the same cycle: capture new data; stay FULL (back-to-back).
  FULL + wr_en, no ack: keep old data; dm_drop=1 for one cycle.
  EMPTY + dm_ack: ignored.
- The staging path is independent of op; a lane op and a capture in the same cycle both take effect, and the capture takes datain, not the new reg value.
- dm_drop is 0 in every cycle with no rejected capture.

Test Plan:
- Reset: drive garbage ops, assert rst one cycle -> all lanes 0, zero=all 1s, ovf=0, dm_valid=0 next cycle.
- LOAD lane0=0xFFFF, lane1=0x0000 (lane_en=0011), then INC -> lane0=0x0000 with ovf[0]=1 and zero[0]=1; lane1=0x0001 with ovf[1]=0; lanes 2–3 unchanged.
- DEC on lane at 0 -> 0xFFFF, ovf=1. Subsequent LOAD 5 -> ovf=0. ADD 0x8000+0x8000 -> 0x0000, ovf=1.
- Staging: wr_en with datain=A -> dm_valid=1, dm_mem_out=A. wr_en with B and no ack -> dm_drop pulse, out stays A. wr_en C with ack -> out=C, dm_valid stays 1. Ack alone -> dm_valid=0.
- Simultaneous: rst=1 with op=LOAD and wr_en=1 -> reset values only, no capture, dm_drop=0.
- Reserved ops 110/111 with all lanes enabled -> registers and flags unchanged.
